if_id_buf: RTL and testbench

Parametrised, elastic IF/ID pipeline stage: a two-entry skid buffer between fetch and decode with valid/ready handshakes on both sides. It carries `{pc, instruction}`. A fetch-kill input converts an entry into a bubble or drops it, selected by `KILL_DROP`. A flush input empties the stage in one cycle. `in_ready` is registered, so no combinational path exists from `out_ready` back to fetch.

---
 rtl/if_id_buf.sv | 152 +++++++++++++++
 tb/tb_if_id_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buf.sv
// if_id_buf: elastic IF/ID pipeline stage built as a two-entry skid buffer.
// The main register drives decode and the skid register absorbs the one extra
// entry that can arrive after decode stalls. in_ready is a register so decode
// backpressure never reaches fetch combinationally.
module if_id_buf #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP       = {ILEN{1'b0}},
  parameter bit              KILL_DROP = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_is,
  input  logic            in_kill,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_is,
  output logic [1:0]      occ
);

  // The state encoding is the occupancy count itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [XLEN-1:0]   r_main_pc;
  logic [ILEN-1:0]   r_main_is;
  logic [XLEN-1:0]   r_skid_pc;
  logic [ILEN-1:0]   r_skid_is;

  logic              w_accept;
  logic              w_write;
  logic              w_fire;
  logic [ILEN-1:0]   w_in_is;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid_in;

  // A killed fetch in drop mode still completes its handshake but is never stored.
  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_write  = w_accept & ~((KILL_DROP != 1'b0) & in_kill);
  assign w_fire   = (r_state != S_EMPTY) & out_ready;
  assign w_in_is  = in_kill ? NOP : in_is;

  // Next-state and register-load selection; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_write) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_write && w_fire) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end else if (w_write) begin
            w_state_nxt    = S_FULL;
            w_load_skid_in = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_ONE;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a drain by decode can change state.
          if (w_fire) begin
            w_state_nxt      = S_ONE;
            w_load_main_skid = 1'b1;
          end else begin
            w_state_nxt = S_FULL;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // State and in_ready registers; in_ready is precomputed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Main payload register; flush forces a bubble but leaves the PC untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_pc <= {XLEN{1'b0}};
      r_main_is <= NOP;
    end else if (flush) begin
      r_main_is <= NOP;
    end else if (w_load_main_in) begin
      r_main_pc <= in_pc;
      r_main_is <= w_in_is;
    end else if (w_load_main_skid) begin
      r_main_pc <= r_skid_pc;
      r_main_is <= r_skid_is;
    end else begin
      r_main_pc <= r_main_pc;
      r_main_is <= r_main_is;
    end
  end

  // Skid payload register; its validity is implied by the FULL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_pc <= {XLEN{1'b0}};
      r_skid_is <= NOP;
    end else if (w_load_skid_in) begin
      r_skid_pc <= in_pc;
      r_skid_is <= w_in_is;
    end else begin
      r_skid_pc <= r_skid_pc;
      r_skid_is <= r_skid_is;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_pc    = r_main_pc;
  assign out_is    = r_main_is;
  assign occ       = r_state;

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: one instance per kill mode, both driven by the same
// stimulus and compared every cycle against a two-slot FIFO reference model.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_kill;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_pc;
  logic [31:0] in_is;

  logic        in_ready_s  [2];
  logic        out_valid_s [2];
  logic [31:0] out_pc_s    [2];
  logic [31:0] out_is_s    [2];
  logic [1:0]  occ_s       [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: entries held per instance, oldest first.
  int          m_cnt   [2];
  logic [31:0] m_pc    [2][2];
  logic [31:0] m_is    [2][2];
  bit          m_known [2];
  logic [31:0] m_kpc   [2];

  // Entries actually taken by decode, recorded from the DUT pins.
  logic [31:0] log_pc [2][0:1023];
  logic [31:0] log_is [2][0:1023];
  int          log_n  [2];

  always #5 clk = ~clk;

  if_id_buf #(.XLEN(32), .ILEN(32), .NOP(32'h0), .KILL_DROP(1'b0)) u_keep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .in_pc(in_pc), .in_is(in_is), .in_kill(in_kill), .flush(flush),
    .out_valid(out_valid_s[0]), .out_ready(out_ready), .out_pc(out_pc_s[0]),
    .out_is(out_is_s[0]), .occ(occ_s[0])
  );

  if_id_buf #(.XLEN(32), .ILEN(32), .NOP(32'h0), .KILL_DROP(1'b1)) u_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .in_pc(in_pc), .in_is(in_is), .in_kill(in_kill), .flush(flush),
    .out_valid(out_valid_s[1]), .out_ready(out_ready), .out_pc(out_pc_s[1]),
    .out_is(out_is_s[1]), .occ(occ_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int k);
    bit acc;
    bit fire;
    if (rst) begin
      m_cnt[k]   = 0;
      m_known[k] = 1'b1;
      m_kpc[k]   = 32'h0;
    end else begin
      acc  = in_valid && (m_cnt[k] < 2) && !flush;
      fire = (m_cnt[k] > 0) && out_ready;
      if (flush) begin
        if (m_cnt[k] > 0) begin
          m_known[k] = 1'b1;
          m_kpc[k]   = m_pc[k][0];
        end
        m_cnt[k] = 0;
      end else begin
        if (fire) begin
          m_pc[k][0] = m_pc[k][1];
          m_is[k][0] = m_is[k][1];
          m_cnt[k]   = m_cnt[k] - 1;
        end
        if (acc && !(k == 1 && in_kill)) begin
          m_pc[k][m_cnt[k]] = in_pc;
          m_is[k][m_cnt[k]] = in_kill ? 32'h0 : in_is;
          m_cnt[k]          = m_cnt[k] + 1;
          m_known[k]        = 1'b0;
        end
      end
    end
  endtask

  task automatic check_inst(input int k);
    chk($sformatf("k%0d_valid", k), {31'h0, out_valid_s[k]}, (m_cnt[k] > 0) ? 32'h1 : 32'h0);
    chk($sformatf("k%0d_occ", k), {30'h0, occ_s[k]}, m_cnt[k]);
    chk($sformatf("k%0d_in_ready", k), {31'h0, in_ready_s[k]}, (m_cnt[k] != 2) ? 32'h1 : 32'h0);
    if (m_cnt[k] > 0) begin
      chk($sformatf("k%0d_out_pc", k), out_pc_s[k], m_pc[k][0]);
      chk($sformatf("k%0d_out_is", k), out_is_s[k], m_is[k][0]);
    end else if (m_known[k]) begin
      chk($sformatf("k%0d_idle_pc", k), out_pc_s[k], m_kpc[k]);
      chk($sformatf("k%0d_idle_is", k), out_is_s[k], 32'h0);
    end
  endtask

  // One clock: log DUT fires, advance the model at the edge, check after it.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (out_valid_s[k] && out_ready && log_n[k] < 1024) begin
        log_pc[k][log_n[k]] = out_pc_s[k];
        log_is[k][log_n[k]] = out_is_s[k];
        log_n[k]++;
      end
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  // Offer one entry and hold it until the keep-mode instance takes it.
  task automatic send(input logic [31:0] pc, input logic [31:0] is, input logic kill);
    bit done = 1'b0;
    bit took;
    in_valid = 1'b1;
    in_pc    = pc;
    in_is    = is;
    in_kill  = kill;
    for (int t = 0; t < 20; t++) begin
      took = in_ready_s[0];
      step();
      if (took) begin
        done = 1'b1;
        break;
      end
    end
    chk("send_timeout", {31'h0, done}, 32'h1);
    in_valid = 1'b0;
    in_kill  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int base0;
    int base1;
    int c0;
    log_n[0] = 0;
    log_n[1] = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_known[0] = 1'b0;
    m_known[1] = 1'b0;
    m_kpc[0] = 32'h0;
    m_kpc[1] = 32'h0;

    // Reset held two cycles while fetch offers an entry.
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h55; in_is = 32'h1234_5678;
    in_kill = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    step();
    step();
    rst = 1'b0;
    send(32'h10, 32'h0000_0013, 1'b0);
    out_ready = 1'b1;
    idle(2);

    // Streaming at full rate.
    base0 = log_n[0];
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(i * 4, (i * 4) ^ 32'hA5A5_A5A5, 1'b0);
    chk("stream_cycles", cyc - c0, 32'd16);
    idle(2);
    chk("stream_count", log_n[0] - base0, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_pc", log_pc[0][base0 + i], i * 4);
      chk("stream_is", log_is[0][base0 + i], (i * 4) ^ 32'hA5A5_A5A5);
    end

    // Backpressure: two entries absorbed, the third waits.
    out_ready = 1'b0;
    base0 = log_n[0];
    send(32'h0, 32'hA5A5_A5A5, 1'b0);
    send(32'h4, 32'hA5A5_A5A1, 1'b0);
    in_valid = 1'b1; in_pc = 32'h8; in_is = 32'hA5A5_A5AD;
    step();
    step();
    step();
    chk("bp_occ", {30'h0, occ_s[0]}, 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("bp_count", log_n[0] - base0, 32'd2);
    chk("bp_first", log_pc[0][base0], 32'h0);
    chk("bp_second", log_pc[0][base0 + 1], 32'h4);

    // Kill handling in both modes.
    base0 = log_n[0];
    base1 = log_n[1];
    send(32'h100, 32'h0000_0093, 1'b0);
    send(32'h104, 32'hDEAD_BEEF, 1'b1);
    send(32'h108, 32'h0000_0113, 1'b0);
    idle(3);
    chk("kill_keep_count", log_n[0] - base0, 32'd3);
    chk("kill_keep_pc0", log_pc[0][base0], 32'h100);
    chk("kill_keep_pc1", log_pc[0][base0 + 1], 32'h104);
    chk("kill_keep_nop", log_is[0][base0 + 1], 32'h0);
    chk("kill_keep_pc2", log_pc[0][base0 + 2], 32'h108);
    chk("kill_drop_count", log_n[1] - base1, 32'd2);
    chk("kill_drop_pc0", log_pc[1][base1], 32'h100);
    chk("kill_drop_pc1", log_pc[1][base1 + 1], 32'h108);

    // Flush while full, with a new entry offered the same cycle.
    out_ready = 1'b0;
    send(32'h300, 32'h0000_0293, 1'b0);
    send(32'h304, 32'h0000_0313, 1'b0);
    in_valid = 1'b1; in_pc = 32'h200; in_is = 32'h0000_0393; flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_full_occ", {30'h0, occ_s[0]}, 32'd0);
    base0 = log_n[0];
    out_ready = 1'b1;
    idle(3);
    chk("flush_full_noout", log_n[0] - base0, 32'd0);

    // Flush coincident with a fire.
    out_ready = 1'b0;
    send(32'h400, 32'h0000_0413, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    base0 = log_n[0];
    step();
    flush = 1'b0;
    idle(3);
    chk("flush_fire_count", log_n[0] - base0, 32'd1);
    chk("flush_fire_pc", log_pc[0][base0], 32'h400);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(99) == 0);
      in_valid  = $urandom_range(1);
      in_pc     = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      in_is     = $urandom;
      in_kill   = ($urandom_range(3) == 0);
      flush     = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_kill = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
